// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer for a shared single-port RAM. Each access runs
//   arbitrate (IDLE or RESP edge) -> ACCESS (gnt, RAM cycle) -> RESP (ack), 2 cycles sample-to-ack.
// Ports: clk, rst (async, active-high); per requester N: reqN/wrN/addrN/wdataN in, gntN/ackN/rdataN out;
//   busy out; RAM side: ram_addr/ram_data/ram_we out, ram_x in (combinational read of ram_addr).
module ram_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_x
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q;
  // last_q doubles as the id of the port currently being served: it is
  // written exactly when a winner is latched.
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              gnt0_q, gnt1_q, ack0_q, ack1_q, busy_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              any_req;
  logic              sel_d;
  logic              sel_wr_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  // Winner selection on the current requests; only used at arbitration edges.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      sel_d = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      sel_d = req1;
    end
    sel_wr_d    = sel_d ? wr1    : wr0;
    sel_addr_d  = sel_d ? addr1  : addr0;
    sel_wdata_d = sel_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;  // first tie goes to port 0
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      // Pulsed outputs default low; each lasts exactly one state.
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (any_req) begin
            state_q <= ACCESS;
            last_q  <= sel_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            we_q    <= sel_wr_d;
            gnt0_q  <= ~sel_d;
            gnt1_q  <= sel_d;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          ack0_q  <= ~last_q;
          ack1_q  <= last_q;
          // In ACCESS we_q is the latched direction; reads capture the RAM output.
          if (!we_q) begin
            if (last_q) rdata1_q <= ram_x;
            else        rdata0_q <= ram_x;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = busy_q;
  assign ram_addr = addr_q;
  assign ram_data = wdata_q;
  assign ram_we   = we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: two instances (round-robin and fixed priority), each with its own RAM,
// directed scenarios with literal expectations plus randomized requesters checked every cycle
// against a transaction-level model (arbitration edge -> access cycle -> response cycle).
module tb_ram_arbiter;
  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0 [2], req1 [2], wr0 [2], wr1 [2];
  logic [AW-1:0] addr0 [2], addr1 [2];
  logic [DW-1:0] wdata0 [2], wdata1 [2];
  logic          gnt0 [2], gnt1 [2], ack0 [2], ack1 [2], busy [2], ram_we [2];
  logic [DW-1:0] rdata0 [2], rdata1 [2], ram_data [2], ram_x [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] mem [2][64];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g == 1)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .req1(req1[g]), .wr0(wr0[g]), .wr1(wr1[g]),
      .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
      .gnt0(gnt0[g]), .gnt1(gnt1[g]), .ack0(ack0[g]), .ack1(ack1[g]),
      .rdata0(rdata0[g]), .rdata1(rdata1[g]), .busy(busy[g]),
      .ram_addr(ram_addr[g]), .ram_data(ram_data[g]), .ram_we(ram_we[g]), .ram_x(ram_x[g])
    );
    assign ram_x[g] = mem[g][ram_addr[g]];
  end

  // RAM instances: combinational read, write on the rising edge.
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (ram_we[g]) mem[g][ram_addr[g]] = ram_data[g];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          m_acc [2], m_resp [2];   // transaction in its access / response cycle
  bit            m_acc_v [2], m_resp_v [2], m_last [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  logic [DW-1:0] m_rd [2][2];
  logic [DW-1:0] emem [2][64];

  task automatic model_reset(input int i);
    m_acc_v[i]  = 1'b0;
    m_resp_v[i] = 1'b0;
    m_last[i]   = 1'b1;
    m_addr[i]   = '0;
    m_data[i]   = '0;
    m_rd[i][0]  = '0;
    m_rd[i][1]  = '0;
  endtask

  task automatic model_step(input int i);
    bit   arb;
    bit   w;
    txn_t t;
    arb = !m_acc_v[i];  // arbitration happens at every edge that does not end an access cycle
    if (m_acc_v[i]) begin
      if (m_acc[i].wr) emem[i][m_acc[i].addr] = m_acc[i].wdata;
      else             m_rd[i][m_acc[i].port] = emem[i][m_acc[i].addr];
    end
    m_resp_v[i] = m_acc_v[i];
    m_resp[i]   = m_acc[i];
    m_acc_v[i]  = 1'b0;
    if (arb && (req0[i] || req1[i])) begin
      if (req0[i] && req1[i]) w = (i == 1) ? 1'b0 : !m_last[i];
      else                    w = req1[i];
      t.port  = w;
      t.wr    = w ? wr1[i]    : wr0[i];
      t.addr  = w ? addr1[i]  : addr0[i];
      t.wdata = w ? wdata1[i] : wdata0[i];
      m_acc[i]   = t;
      m_acc_v[i] = 1'b1;
      m_last[i]  = w;
      m_addr[i]  = t.addr;
      m_data[i]  = t.wdata;
    end
  endtask

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (rst) model_reset(i);
      else     model_step(i);
    end

  function automatic logic [35:0] exp_vec(input int i);
    return {m_acc_v[i] && !m_acc[i].port, m_acc_v[i] && m_acc[i].port,
            m_resp_v[i] && !m_resp[i].port, m_resp_v[i] && m_resp[i].port,
            m_acc_v[i] || m_resp_v[i], m_acc_v[i] && m_acc[i].wr,
            m_addr[i], m_data[i], m_rd[i][0], m_rd[i][1]};
  endfunction

  function automatic logic [35:0] act_vec(input int i);
    return {gnt0[i], gnt1[i], ack0[i], ack1[i], busy[i], ram_we[i],
            ram_addr[i], ram_data[i], rdata0[i], rdata1[i]};
  endfunction

  // Per-cycle comparison of every output of both instances.
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      chk($sformatf("outputs_dut%0d", i), 64'(act_vec(i)), 64'(exp_vec(i)));

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0[i] = r; wr0[i] = w; addr0[i] = a; wdata0[i] = d; end
    else        begin req1[i] = r; wr1[i] = w; addr1[i] = a; wdata1[i] = d; end
  endtask

  function automatic logic gnt_of(input int i, input int p);
    return (p == 0) ? gnt0[i] : gnt1[i];
  endfunction

  function automatic logic req_of(input int i, input int p);
    return (p == 0) ? req0[i] : req1[i];
  endfunction

  task automatic poke(input int i, input int a, input logic [DW-1:0] d);
    mem[i][a]  = d;
    emem[i][a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] ga(input int i);
    return {gnt0[i], gnt1[i], ack0[i], ack1[i]};
  endfunction

  bit            gseen [2][2];
  logic [DW-1:0] v0, v1;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 1'b0, 1'b0, '0, '0);
      drive(i, 1, 1'b0, 1'b0, '0, '0);
      model_reset(i);
      for (int a = 0; a < 64; a++) poke(i, a, DW'($urandom));
      gseen[i][0] = 1'b0;
      gseen[i][1] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("reset_state_rr", 64'(act_vec(0)), 64'd0);
    chk("reset_state_fp", 64'(act_vec(1)), 64'd0);
    rst = 1'b0;

    // Single read, port 0, addr 3
    poke(0, 3, 8'hA5);
    drive(0, 0, 1'b1, 1'b0, 6'd3, 8'h00);
    @(negedge clk);
    chk("read_gnt0_cycle", 64'(ga(0)), 64'(4'b1000));
    @(negedge clk);
    chk("read_ack0_cycle", 64'(ga(0)), 64'(4'b0010));
    chk("read_rdata0", 64'(rdata0[0]), 64'hA5);
    chk("read_rdata1_zero", 64'(rdata1[0]), 64'h00);
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Port 1: write 3C to addr 63, then read it back-to-back
    drive(0, 1, 1'b1, 1'b1, 6'd63, 8'h3C);
    @(negedge clk);
    chk("write_we_gnt1", 64'({ram_we[0], gnt1[0]}), 64'(2'b11));
    @(negedge clk);
    chk("write_ack1_we_low", 64'({ram_we[0], ack1[0]}), 64'(2'b01));
    chk("write_keeps_rdata1", 64'(rdata1[0]), 64'h00);
    drive(0, 1, 1'b1, 1'b0, 6'd63, 8'h00);
    @(negedge clk);
    chk("readback_gnt1_no_we", 64'({ram_we[0], gnt1[0]}), 64'(2'b01));
    @(negedge clk);
    chk("readback_ack1", 64'(ack1[0]), 64'd1);
    chk("readback_rdata1", 64'(rdata1[0]), 64'h3C);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Tie round-robin after reset: grants alternate 0,1,0,1
    do_reset();
    v0 = DW'($urandom);
    v1 = DW'($urandom);
    poke(0, 0, v0);
    poke(0, 1, v1);
    drive(0, 0, 1'b1, 1'b0, 6'd0, 8'h00);
    drive(0, 1, 1'b1, 1'b0, 6'd1, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      case (k % 4)
        0:       chk("rr_pattern", 64'({ga(0), busy[0]}), 64'(5'b10001));
        1:       chk("rr_pattern", 64'({ga(0), busy[0]}), 64'(5'b00101));
        2:       chk("rr_pattern", 64'({ga(0), busy[0]}), 64'(5'b01001));
        default: chk("rr_pattern", 64'({ga(0), busy[0]}), 64'(5'b00011));
      endcase
    end
    chk("rr_rdata0", 64'(rdata0[0]), 64'(v0));
    chk("rr_rdata1", 64'(rdata1[0]), 64'(v1));
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Fixed priority instance: port 0 takes every tie, then port 1 once req0 drops
    drive(1, 0, 1'b1, 1'b0, 6'd10, 8'h00);
    drive(1, 1, 1'b1, 1'b0, 6'd20, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fp_port0_only", 64'({gnt0[1], gnt1[1]}), (k % 2 == 0) ? 64'(2'b10) : 64'(2'b00));
    end
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("fp_port1_after_drop", 64'({gnt0[1], gnt1[1]}), 64'(2'b01));
    @(negedge clk);
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);

    // Reset in the middle of a write to addr 5
    poke(0, 5, 8'h11);
    drive(0, 0, 1'b1, 1'b1, 6'd5, 8'hFF);
    @(posedge clk);
    #2;
    chk("midwrite_we_before_rst", 64'(ram_we[0]), 64'd1);
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
    chk("midwrite_we_dropped", 64'(ram_we[0]), 64'd0);
    chk("midwrite_outputs_zero", 64'(act_vec(0)), 64'd0);
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midwrite_ram5_kept", 64'(mem[0][5]), 64'h11);
    chk("midwrite_idle", 64'({busy[0], ga(0)}), 64'd0);

    // Idle hold after an access to addr 9
    drive(0, 0, 1'b1, 1'b0, 6'd9, 8'h00);
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_hold", 64'({busy[0], ram_we[0], ga(0), ram_addr[0]}), 64'({6'b0, 6'd9}));
    end

    // Randomized requesters on both instances; last cycles only drain.
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (gnt_of(i, p)) begin
            gseen[i][p] = 1'b1;
          end else if (gseen[i][p]) begin
            gseen[i][p] = 1'b0;
            if (c < NCYC - 20 && $urandom_range(1, 0) == 1)
              drive(i, p, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
            else
              drive(i, p, 1'b0, 1'b0, '0, '0);
          end else if (!req_of(i, p) && c < NCYC - 20 && $urandom_range(9, 0) < 4) begin
            drive(i, p, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
          end
        end
      end
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int bad;
      bad = 0;
      for (int a = 0; a < 64; a++)
        if (mem[i][a] !== emem[i][a]) bad++;
      chk($sformatf("ram_contents_dut%0d", i), 64'(bad), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
